// File: rtl/seg_pkg.sv
// Shared definitions for the seg_mmio display register block.
// SEG_MMIO_BCD_EN: when defined, the auto-count runs as two-digit BCD
// instead of plain binary.
package seg_pkg;

   localparam int unsigned SEG_DATA_W = 8;
   localparam int unsigned SEG_DIV_W  = 24;

   // Register offsets, word index taken from mem_addr[3:2]
   typedef enum logic [1:0] {
      SEG_OFF_DATA = 2'd0,
      SEG_OFF_CTRL = 2'd1,
      SEG_OFF_DIV  = 2'd2,
      SEG_OFF_RSVD = 2'd3
   } seg_off_t;

   // CTRL bit indices
   localparam int unsigned SEG_CTRL_BLANK    = 0;
   localparam int unsigned SEG_CTRL_BLINK_EN = 1;
   localparam int unsigned SEG_CTRL_AUTO_EN  = 2;
   localparam int unsigned SEG_CTRL_W        = 3;

   typedef logic [SEG_CTRL_W-1:0] seg_ctrl_t;

   // Next displayed value for one auto-count step
   function automatic logic [SEG_DATA_W-1:0] seg_next_count(input logic [SEG_DATA_W-1:0] d);
`ifdef SEG_MMIO_BCD_EN
      logic [3:0] lo;
      logic [3:0] hi;
      logic       carry;
      lo    = d[3:0];
      hi    = d[7:4];
      carry = (lo >= 4'd9);
      lo    = carry ? 4'd0 : lo + 4'd1;
      hi    = carry ? hi + 4'd1 : hi;
      // A non-decimal tens digit (written by the CPU) collapses to 0
      if (hi > 4'd9) hi = 4'd0;
      return {hi, lo};
`else
      return d + 8'd1;
`endif
   endfunction

endpackage

// File: rtl/seg_mmio_if.sv
// picorv32 native memory bus bundle for the seg_mmio register block.
interface seg_mmio_if;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/seg_prescaler.sv
// Free-running prescaler: produces a one-cycle tick every DIV cycles while
// enabled. DIV=0 is treated as DIV=1; a DIV write restarts the count.
module seg_prescaler
   import seg_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run_i,
   input  logic                 clr_i,
   input  logic [SEG_DIV_W-1:0] div_i,
   output logic                 tick_o
);

   logic [SEG_DIV_W-1:0] cnt_q, cnt_d;
   logic [SEG_DIV_W-1:0] term;

   // Terminal count and next counter value
   always_comb begin
      term   = (div_i == '0) ? '0 : div_i - 24'd1;
      tick_o = run_i && (cnt_q == term);
      if (clr_i || !run_i || tick_o) cnt_d = '0;
      else                           cnt_d = cnt_q + 24'd1;
   end

   // Counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/seg_mmio.sv
// Memory-mapped two-digit seven-segment display register with blank,
// prescaled blink and prescaled auto-count.
// SEG_MMIO_BCD_EN: when defined, the auto-count is two-digit BCD.
module seg_mmio
   import seg_pkg::*;
#(
   parameter logic [31:0]          BASE_ADDR = 32'h0300_0000,
   parameter logic [SEG_DIV_W-1:0] DIV_RESET = 24'd12_000_000
) (
   input  logic        clk,
   input  logic        rst,
   seg_mmio_if.slave   bus,
   output logic [3:0]  seg_data_1,
   output logic [3:0]  seg_data_2,
   output logic        seg_blank
);

   logic [SEG_DATA_W-1:0] data_q, data_d;
   seg_ctrl_t             ctrl_q, ctrl_d;
   logic [SEG_DIV_W-1:0]  div_q, div_d;
   logic                  phase_q, phase_d;
   logic                  ready_q, ready_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [3:0]            seg1_q, seg2_q;
   logic                  blank_q, blank_d;

   logic                  sel, accept, wr_en, div_wr, tick;
   seg_off_t              off;
   logic [31:0]           rd_mux;
   logic                  unused_bits;

   assign unused_bits = ^{bus.mem_addr[1:0], bus.mem_wdata[31:24], bus.mem_wstrb[3]};

   // Address decode, accept qualification and read mux
   always_comb begin
      sel    = bus.mem_valid && (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
      accept = sel && !ready_q;
      wr_en  = accept && (bus.mem_wstrb != 4'b0000);
      off    = seg_off_t'(bus.mem_addr[3:2]);
      div_wr = wr_en && (off == SEG_OFF_DIV);
      rd_mux = '0;
      case (off)
         SEG_OFF_DATA: rd_mux[SEG_DATA_W-1:0] = data_q;
         SEG_OFF_CTRL: rd_mux[SEG_CTRL_W-1:0] = ctrl_q;
         SEG_OFF_DIV:  rd_mux[SEG_DIV_W-1:0]  = div_q;
         default:      rd_mux = '0;
      endcase
   end

   seg_prescaler u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .run_i  (ctrl_q[SEG_CTRL_BLINK_EN] | ctrl_q[SEG_CTRL_AUTO_EN]),
      .clr_i  (div_wr),
      .div_i  (div_q),
      .tick_o (tick)
   );

   // Register next-state: CPU write to DATA overrides a coincident increment
   always_comb begin
      data_d = data_q;
      if (tick && ctrl_q[SEG_CTRL_AUTO_EN]) data_d = seg_next_count(data_q);
      if (wr_en && (off == SEG_OFF_DATA) && bus.mem_wstrb[0]) data_d = bus.mem_wdata[7:0];

      ctrl_d = ctrl_q;
      if (wr_en && (off == SEG_OFF_CTRL) && bus.mem_wstrb[0]) ctrl_d = bus.mem_wdata[SEG_CTRL_W-1:0];

      div_d = div_q;
      for (int unsigned i = 0; i < 3; i++) begin
         if (div_wr && bus.mem_wstrb[i]) div_d[i*8 +: 8] = bus.mem_wdata[i*8 +: 8];
      end

      phase_d = ctrl_q[SEG_CTRL_BLINK_EN] ? (phase_q ^ tick) : 1'b0;
      blank_d = ctrl_q[SEG_CTRL_BLANK] | (ctrl_q[SEG_CTRL_BLINK_EN] & phase_q);

      ready_d = accept;
      rdata_d = accept ? rd_mux : '0;
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         ctrl_q  <= '0;
         div_q   <= DIV_RESET;
         phase_q <= 1'b0;
         ready_q <= 1'b0;
         rdata_q <= '0;
         seg1_q  <= '0;
         seg2_q  <= '0;
         blank_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
         div_q   <= div_d;
         phase_q <= phase_d;
         ready_q <= ready_d;
         rdata_q <= rdata_d;
         seg1_q  <= data_q[3:0];
         seg2_q  <= data_q[7:4];
         blank_q <= blank_d;
      end
   end

   assign bus.mem_ready = ready_q;
   assign bus.mem_rdata = rdata_q;
   assign seg_data_1    = seg1_q;
   assign seg_data_2    = seg2_q;
   assign seg_blank     = blank_q;

endmodule

// File: tb/tb_seg_mmio.sv
// Scoreboard bench for seg_mmio: randomized bus traffic against a
// cycle-level behavioural model of the register map.
module tb_seg_mmio;
   import seg_pkg::*;

   localparam logic [31:0] BASE = 32'h0300_0000;
   localparam logic [23:0] DIVR = 24'd12_000_000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] sd1, sd2;
   logic       sb;

   seg_mmio_if bus();

   seg_mmio #(.BASE_ADDR(BASE), .DIV_RESET(DIVR)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .seg_data_1 (sd1),
      .seg_data_2 (sd2),
      .seg_blank  (sb)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          is_read;
      logic [31:0] rdata;
      int unsigned cyc;
   } exp_t;
   exp_t sbq[$];

   // Reference state
   logic [7:0]  m_data  = '0;
   logic [2:0]  m_ctrl  = '0;
   logic [23:0] m_div   = DIVR;
   logic        m_phase = 1'b0;
   logic        m_ready = 1'b0;
   logic [3:0]  e_sd1   = '0;
   logic [3:0]  e_sd2   = '0;
   logic        e_sb    = 1'b0;
   int unsigned m_cyc   = 0;
   int unsigned m_anchor = 0;
   bit          started = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_inc(input logic [7:0] d);
`ifdef SEG_MMIO_BCD_EN
      int lo, hi;
      lo = int'(d) % 16;
      hi = int'(d) / 16;
      if (lo >= 9) begin lo = 0; hi = hi + 1; end
      else lo = lo + 1;
      if (hi > 9) hi = 0;
      return 8'(hi * 16 + lo);
`else
      return 8'((int'(d) + 1) % 256);
`endif
   endfunction

   function automatic logic [31:0] ref_read(input logic [1:0] off);
      case (off)
         2'd0:    return {24'h0, m_data};
         2'd1:    return {29'h0, m_ctrl};
         2'd2:    return {8'h0, m_div};
         default: return 32'h0;
      endcase
   endfunction

   // Reference model: evaluates the cycle that just ended at each rising edge
   always @(posedge clk) begin
      bit          sel, acc, wr, running, tick;
      logic [1:0]  off;
      int unsigned d_eff;
      logic [7:0]  nd;
      if (rst) begin
         m_data = '0; m_ctrl = '0; m_div = DIVR; m_phase = 0; m_ready = 0;
         e_sd1 = '0; e_sd2 = '0; e_sb = 0;
         m_anchor = m_cyc + 1;
      end else begin
         sel     = bus.mem_valid && (bus.mem_addr[31:4] == BASE[31:4]);
         acc     = sel && !m_ready;
         off     = bus.mem_addr[3:2];
         wr      = acc && (bus.mem_wstrb != 4'b0000);
         running = m_ctrl[1] || m_ctrl[2];
         d_eff   = (m_div == 0) ? 1 : int'(m_div);
         tick    = running && (((m_cyc - m_anchor) % d_eff) == d_eff - 1);
         e_sd1 = m_data[3:0];
         e_sd2 = m_data[7:4];
         e_sb  = m_ctrl[0] | (m_ctrl[1] & m_phase);
         if (acc) sbq.push_back('{bus.mem_wstrb == 4'b0000, ref_read(off), m_cyc});
         m_phase = m_ctrl[1] ? (m_phase ^ tick) : 1'b0;
         nd = m_data;
         if (tick && m_ctrl[2]) nd = ref_inc(m_data);
         if (wr && off == 2'd0 && bus.mem_wstrb[0]) nd = bus.mem_wdata[7:0];
         if ((wr && off == 2'd2) || !running) m_anchor = m_cyc + 1;
         if (wr && off == 2'd1 && bus.mem_wstrb[0]) m_ctrl = bus.mem_wdata[2:0];
         if (wr && off == 2'd2) begin
            for (int i = 0; i < 3; i++)
               if (bus.mem_wstrb[i]) m_div[i*8 +: 8] = bus.mem_wdata[i*8 +: 8];
         end
         m_data  = nd;
         m_ready = acc;
      end
      started = 1;
      m_cyc   = m_cyc + 1;
   end

   // Monitor: compares DUT outputs against the model away from the clock edge
   always @(negedge clk) begin
      exp_t e;
      if (started && !rst) begin
         chk("mem_ready", {31'h0, bus.mem_ready}, {31'h0, m_ready});
         if (bus.mem_ready) begin
            if (sbq.size() == 0) begin
               chk("unexpected_ack", 32'h1, 32'h0);
            end else begin
               e = sbq.pop_front();
               chk("ack_latency", m_cyc, e.cyc + 1);
               if (e.is_read) chk("rdata", bus.mem_rdata, e.rdata);
            end
         end else begin
            chk("rdata_idle", bus.mem_rdata, 32'h0);
         end
         chk("seg_data_1", {28'h0, sd1}, {28'h0, e_sd1});
         chk("seg_data_2", {28'h0, sd2}, {28'h0, e_sd2});
         chk("seg_blank",  {31'h0, sb},  {31'h0, e_sb});
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic xfer(input logic [1:0] off, input logic [31:0] d, input logic [3:0] s);
      bit got;
      got = 0;
      @(posedge clk); #1;
      bus.mem_valid = 1'b1;
      bus.mem_addr  = BASE | {28'h0, off, 2'b00};
      bus.mem_wdata = d;
      bus.mem_wstrb = s;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bus.mem_ready) begin got = 1; break; end
      end
      if (!got) chk("ack_timeout", 32'h0, 32'h1);
      bus.mem_valid = 1'b0;
      bus.mem_wstrb = 4'b0000;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.mem_valid = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_wstrb = '0;
      idle(3); #1 rst = 1'b0;

      // Reset contents
      for (int r = 0; r < 4; r++) xfer(2'(r), 32'h0, 4'b0000);

      // Byte-lane writes
      xfer(2'd0, 32'h0000_003C, 4'b0001);
      idle(2);
      xfer(2'd0, 32'h1234_5677, 4'b0010);
      xfer(2'd0, 32'h0, 4'b0000);

      // Binary wrap under auto-count, then DATA writes at varied phases
      xfer(2'd2, 32'd3, 4'b0111);
      xfer(2'd0, 32'hFE, 4'b0001);
      xfer(2'd1, 32'h4, 4'b0001);
      idle(10);
      for (int k = 0; k < 6; k++) begin
         xfer(2'd0, 32'h50 + 32'(k), 4'b0001);
         idle(k);
      end
      idle(4);

      // Blink then static blank
      xfer(2'd2, 32'd2, 4'b0111);
      xfer(2'd1, 32'h2, 4'b0001);
      idle(10);
      xfer(2'd1, 32'h1, 4'b0001);
      idle(5);
      xfer(2'd1, 32'h0, 4'b0000);

      // Unselected address held valid
      @(posedge clk); #1;
      bus.mem_valid = 1'b1;
      bus.mem_addr  = 32'h0200_0000;
      bus.mem_wdata = 32'hFF;
      bus.mem_wstrb = 4'b0001;
      idle(8); #1;
      bus.mem_valid = 1'b0;
      bus.mem_wstrb = 4'b0000;

      // Reset arriving during the request cycle of a DATA write
      @(posedge clk); #1;
      bus.mem_valid = 1'b1;
      bus.mem_addr  = BASE;
      bus.mem_wdata = 32'hAA;
      bus.mem_wstrb = 4'b0001;
      #5 rst = 1'b1;
      @(posedge clk); #1;
      bus.mem_valid = 1'b0;
      bus.mem_wstrb = 4'b0000;
      @(posedge clk); #1 rst = 1'b0;
      idle(2);
      xfer(2'd0, 32'h0, 4'b0000);

`ifdef SEG_MMIO_BCD_EN
      xfer(2'd2, 32'd1, 4'b0111);
      xfer(2'd0, 32'h98, 4'b0001);
      xfer(2'd1, 32'h4, 4'b0001);
      idle(3);
      xfer(2'd1, 32'h0, 4'b0001);
      xfer(2'd0, 32'h0A, 4'b0001);
      xfer(2'd1, 32'h4, 4'b0001);
      idle(3);
      xfer(2'd1, 32'h0, 4'b0001);
`endif

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         logic [1:0]  off;
         logic [3:0]  s;
         logic [31:0] d;
         off = 2'($urandom_range(0, 3));
         s   = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
         d   = $urandom;
         if (off == 2'd2 && s != 4'b0000) begin
            s = 4'b0111;
            d = $urandom_range(0, 6);
         end
         xfer(off, d, s);
         idle($urandom_range(0, 3));
      end

      idle(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_mmio.md
Name: seg_mmio

Overview:
- Memory-mapped display register on the picorv32 native memory bus.
- Holds one byte for the two-digit seven-segment display and drives the two 4-bit digit inputs of the downstream hex decoder (low nibble on digit 1, high nibble on digit 2).
- Adds a global blank, a prescaled blink and a prescaled auto-count so the board shows activity without CPU load.

Parameters:
- BASE_ADDR, 32'h0300_0000, bus base; decode on bits [31:4].
- DIV_RESET, 24'd12_000_000, reset value of the prescaler divide register; 1 s tick at 12 MHz.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mem_valid  in  1  bus request
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte write strobes; 0 = read
- mem_ready  out  1  one-cycle transfer acknowledge
- mem_rdata  out  32  read data, valid while mem_ready=1
- seg_data_1  out  4  low nibble of DATA, to decoder digit 1
- seg_data_2  out  4  high nibble of DATA, to decoder digit 2
- seg_blank  out  1  1 = display dark; gates the decoder's digit-select lines

Behaviour:
- Registers, selected by offset mem_addr[3:2]:
  - 0 DATA [7:0]
  - 1 CTRL [2:0]: bit0 BLANK, bit1 BLINK_EN, bit2 AUTO_EN
  - 2 DIV [23:0]
  - 3 reserved: reads 0, writes ignored
- Decode: sel = mem_valid & (mem_addr[31:4] == BASE_ADDR[31:4]). Unselected: mem_ready stays 0 and the block does not drive the transfer.
- Handshake:
  - Cycle N: sel & ~mem_ready.
  - Clock edge ending N: commit the write and capture rdata; mem_ready=1 for cycle N+1 only.
  - No new transfer is accepted while mem_ready=1, so a held mem_valid yields exactly one ack per two cycles.
  - Latency 1 cycle, read and write alike.
- Writes honour mem_wstrb per byte lane; unused bits are ignored. Reads zero-extend to 32 bits. mem_rdata is 0 whenever mem_ready=0.
- Prescaler:
  - 24-bit counter cnt runs while BLINK_EN | AUTO_EN; held at 0 otherwise.
  - tick when cnt == DIV-1, then cnt wraps to 0.
  - DIV=0 behaves as DIV=1 (tick every cycle).
  - Any write to DIV clears cnt to 0 on the same edge.
- Auto-count: on a tick with AUTO_EN=1, DATA <= DATA+1, binary, 8'hFF wraps to 8'h00.
- Simultaneous CPU write to DATA and tick: the CPU value wins and the increment is dropped.
- Blink: a phase flop toggles on each tick while BLINK_EN=1 and clears to 0 when BLINK_EN=0.
- seg_blank = BLANK | (BLINK_EN & phase), registered, so it changes 1 cycle after the CTRL write or the tick.
- seg_data_1 = DATA[3:0], seg_data_2 = DATA[7:4], registered, so they change 1 cycle after the write or the tick.
- Reset values:
  - DATA=0, CTRL=0, DIV=DIV_RESET, cnt=0, phase=0
  - mem_ready=0, mem_rdata=0, seg_data_1/2=0, seg_blank=0
- Reset asserted mid-transfer: mem_ready is forced 0, the pending write is lost, and the master must retry.

Optional Feature:
- Macro SEG_MMIO_BCD_EN.
- Defined:
  - Auto-count is two-digit BCD. Low nibble 9 -> 0 with carry; 8'h99 -> 8'h00.
  - A CPU-written non-BCD nibble (A-F) increments to the next BCD-valid value: low nibble >9 -> 0 with carry, high nibble >9 -> 0.
- Undefined: binary count as above.

Decomposition:
- Package seg_pkg holds:
  - register offsets SEG_OFF_DATA/CTRL/DIV
  - CTRL bit indices
  - DIV width 24
  - DATA width 8
- One natural sub-module: seg_prescaler (counter, DIV=0 handling, clear-on-write, tick output).

Test Plan:
- Reset, then read all registers -> DATA=0, CTRL=0, DIV=0x00B71B00; mem_ready pulses exactly 1 cycle after each valid.
- Write DATA=0x3C with wstrb=4'b0001 -> seg_data_1=4'hC and seg_data_2=4'h3 one cycle after the ack. Write 0x12345677 with wstrb=4'b0010 -> DATA unchanged.
- DIV=3, CTRL=AUTO_EN, DATA=0xFE -> DATA becomes 0xFF, then 0x00, with increments every 3 cycles. Write DATA=0x50 on the exact tick cycle -> DATA=0x50, no increment.
- DIV=2, CTRL=BLINK_EN -> seg_blank toggles every 2 cycles. Then CTRL=BLANK only -> seg_blank constant 1, phase cleared.
- Hold mem_valid with an unselected address 0x0200_0000 -> mem_ready never asserts. Assert rst during cycle N of a DATA write -> DATA stays 0 and no ack.
- With SEG_MMIO_BCD_EN: DIV=1, DATA=0x98 -> 0x99 -> 0x00; DATA=0x0A -> 0x10.
